// File: rtl/eva_ahb_regbank.sv
// eva_ahb_regbank: AHB-Lite slave register bank with a down-counting timer
// and a maskable, registered interrupt vector.
//
// Ports:
//   hclk        clock, all logic on posedge
//   rst_n       synchronous active-low reset
//   htrans      transfer type; htrans[1]=1 (NONSEQ/SEQ) starts a transfer
//   hwrite      1 = write
//   haddr       byte address; block selected when haddr[31:8] == BASE_ADDR[31:8]
//   hsize       transfer size; only word (3'b010) is legal
//   hwdata      write data, valid in the data phase
//   hready_in   bus-level ready, qualifies the address phase
//   hready_out  slave ready; 0 extends the data phase
//   hresp       2'b00 OKAY, 2'b01 ERROR
//   hrdata      read data, non-zero only on the completing cycle of a read
//   interrupt   registered INT_RAW & INT_MASK
//   dbg_state   data-phase FSM state (IDLE=0, WAIT=1, ERR1=2, ERR2=3)
//
// Handshake: an address phase is taken on a clock edge where hready_in=1,
// htrans[1]=1, the address hits this block and the FSM is in IDLE. Its data
// phase then runs until a cycle with hready_out=1; that cycle's edge is the
// completion edge (write data committed, read data sampled by the master),
// and a following address phase may be taken on that same edge.

module eva_ahb_regbank #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [31:0] ID_VALUE    = 32'hEFA0_0001
) (
  input  logic        hclk,
  input  logic        rst_n,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [31:0] haddr,
  input  logic [2:0]  hsize,
  input  logic [31:0] hwdata,
  input  logic        hready_in,
  output logic        hready_out,
  output logic [1:0]  hresp,
  output logic [31:0] hrdata,
  output logic [31:0] interrupt,
  output logic [1:0]  dbg_state
);

  localparam logic [1:0] WS = 2'(WAIT_STATES);

  localparam logic [2:0] IDX_SCRATCH = 3'd0;
  localparam logic [2:0] IDX_CTRL    = 3'd1;
  localparam logic [2:0] IDX_LOAD    = 3'd2;
  localparam logic [2:0] IDX_COUNT   = 3'd3;
  localparam logic [2:0] IDX_INT_RAW = 3'd4;
  localparam logic [2:0] IDX_INT_SET = 3'd5;
  localparam logic [2:0] IDX_MASK    = 3'd6;
  localparam logic [2:0] IDX_ID      = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  wait_q, wait_d;
  logic        done_q, done_d;   // current cycle completes an OKAY data phase
  logic        wr_q;
  logic [2:0]  idx_q;

  logic        sel, accept, err_a;

  logic [31:0] scratch_q, load_q, count_q, count_d, raw_q, raw_d, mask_q, irq_q;
  logic [1:0]  ctrl_q;
  logic [31:0] rd_val, w1c_bits, set_bits;
  logic        wr_en, hw_set;

  // Address bits below word granularity and htrans[0] carry no meaning here.
  logic        unused_bits;
  assign unused_bits = ^{haddr[1:0], htrans[0]};

  assign sel    = (haddr[31:8] == BASE_ADDR[31:8]);
  assign accept = hready_in & htrans[1] & sel & (state_q == ST_IDLE);

  always_comb begin
    err_a = 1'b0;
    if (haddr[7:5] != 3'b000) err_a = 1'b1;                  // unmapped offset
    if (hsize != 3'b010) err_a = 1'b1;                        // non-word size
    if (hwrite && (haddr[4:2] == IDX_COUNT || haddr[4:2] == IDX_ID)) err_a = 1'b1;
    if (!hwrite && haddr[4:2] == IDX_INT_SET) err_a = 1'b1;   // write-only reg
  end

  // Data-phase FSM: state register
  always_ff @(posedge hclk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      wait_q  <= 2'd0;
      done_q  <= 1'b0;
      wr_q    <= 1'b0;
      idx_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      done_q  <= done_d;
      if (accept) begin
        wr_q  <= hwrite;
        idx_q <= haddr[4:2];
      end
    end
  end

  // Data-phase FSM: next state and bus response
  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    done_d     = 1'b0;
    hready_out = 1'b1;
    hresp      = 2'b00;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (err_a) begin
            state_d = ST_ERR1;
          end else if (WS != 2'd0) begin
            state_d = ST_WAIT;
            wait_d  = WS;
          end else begin
            done_d  = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        hready_out = 1'b0;
        if (wait_q == 2'd1) begin
          state_d = ST_IDLE;
          wait_d  = 2'd0;
          done_d  = 1'b1;
        end else begin
          wait_d  = wait_q - 2'd1;
        end
      end
      ST_ERR1: begin
        hready_out = 1'b0;
        hresp      = 2'b01;
        state_d    = ST_ERR2;
      end
      ST_ERR2: begin
        hresp   = 2'b01;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign dbg_state = state_q;

  // Only OKAY phases ever reach done_q, so errored writes cannot commit.
  assign wr_en = done_q & wr_q;

  always_comb begin
    rd_val = '0;
    case (idx_q)
      IDX_SCRATCH: rd_val = scratch_q;
      IDX_CTRL:    rd_val = {30'd0, ctrl_q};
      IDX_LOAD:    rd_val = load_q;
      IDX_COUNT:   rd_val = count_q;
      IDX_INT_RAW: rd_val = raw_q;
      IDX_INT_SET: rd_val = '0;
      IDX_MASK:    rd_val = mask_q;
      IDX_ID:      rd_val = ID_VALUE;
      default:     rd_val = '0;
    endcase
  end

  assign hrdata = (done_q && !wr_q) ? rd_val : 32'd0;

  // Timer and interrupt-status next values. A LOAD write overrides the
  // decrement; sets (timer or INT_SET) are ORed in after the W1C clear.
  always_comb begin
    count_d = count_q;
    hw_set  = 1'b0;
    if (wr_en && idx_q == IDX_LOAD) begin
      count_d = hwdata;
    end else if (ctrl_q[0] && count_q != 32'd0) begin
      count_d = count_q - 32'd1;
      hw_set  = (count_q == 32'd1);
    end else if (ctrl_q[0] && ctrl_q[1]) begin
      count_d = load_q;                      // expired with auto-reload
    end
    w1c_bits = (wr_en && idx_q == IDX_INT_RAW) ? hwdata : 32'd0;
    set_bits = (wr_en && idx_q == IDX_INT_SET) ? hwdata : 32'd0;
    raw_d    = (raw_q & ~w1c_bits) | set_bits | {31'd0, hw_set};
  end

  always_ff @(posedge hclk) begin
    if (!rst_n) begin
      scratch_q <= '0;
      ctrl_q    <= '0;
      load_q    <= '0;
      count_q   <= '0;
      raw_q     <= '0;
      mask_q    <= '0;
      irq_q     <= '0;
    end else begin
      if (wr_en && idx_q == IDX_SCRATCH) scratch_q <= hwdata;
      if (wr_en && idx_q == IDX_CTRL)    ctrl_q    <= hwdata[1:0];
      if (wr_en && idx_q == IDX_LOAD)    load_q    <= hwdata;
      if (wr_en && idx_q == IDX_MASK)    mask_q    <= hwdata;
      count_q <= count_d;
      raw_q   <= raw_d;
      irq_q   <= raw_q & mask_q;
    end
  end

  assign interrupt = irq_q;

endmodule

// File: tb/tb_eva_ahb_regbank.sv
// tb_eva_ahb_regbank: directed bench for eva_ahb_regbank with WAIT_STATES=2
// (OKAY data phase = 3 cycles, ERROR = 2 cycles). Single master, so the
// slave's hready_out is fed back as hready_in.

module tb_eva_ahb_regbank;

  localparam logic [1:0] NONSEQ = 2'b10;
  localparam logic [1:0] IDLE_T = 2'b00;
  localparam logic [2:0] WORD   = 3'b010;

  // clock / reset
  logic hclk = 1'b0;
  always #5 hclk = ~hclk;
  logic rst_n;

  logic [1:0]  htrans;
  logic        hwrite;
  logic [31:0] haddr;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic        hready_out;
  logic [1:0]  hresp;
  logic [31:0] hrdata;
  logic [31:0] interrupt;
  logic [1:0]  dbg_state;

  int tests_run    = 0;
  int tests_failed = 0;
  logic [31:0] exp_q[$];

  eva_ahb_regbank #(
    .BASE_ADDR   (32'h0000_0000),
    .WAIT_STATES (2),
    .ID_VALUE    (32'hEFA0_0001)
  ) u_dut (
    .hclk       (hclk),
    .rst_n      (rst_n),
    .htrans     (htrans),
    .hwrite     (hwrite),
    .haddr      (haddr),
    .hsize      (hsize),
    .hwdata     (hwdata),
    .hready_in  (hready_out),
    .hready_out (hready_out),
    .hresp      (hresp),
    .hrdata     (hrdata),
    .interrupt  (interrupt),
    .dbg_state  (dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge hclk); #1;
    end
  endtask

  // Called #1 after the accepting edge; returns inside the completing cycle.
  task automatic data_phase(output int cycles, output logic [1:0] resp_first,
                            output logic [1:0] resp_last, output logic [31:0] rdata,
                            output logic [31:0] early);
    cycles     = 0;
    early      = '0;
    resp_first = hresp;
    while (hready_out !== 1'b1 && cycles < 16) begin
      early |= hrdata;
      cycles++;
      @(posedge hclk); #1;
    end
    cycles++;
    resp_last = hresp;
    rdata     = hrdata;
  endtask

  // Single non-pipelined transfer; called and returns #1 after an edge.
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [2:0] size, output logic [31:0] rdata,
                      output logic [1:0] r0, output logic [1:0] r1,
                      output int cycles, output logic [31:0] early);
    htrans = NONSEQ;
    hwrite = wr;
    haddr  = addr;
    hsize  = size;
    @(posedge hclk); #1;
    htrans = IDLE_T;
    hwdata = wdata;
    data_phase(cycles, r0, r1, rdata, early);
    @(posedge hclk); #1;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] rd, early;
    logic [1:0]  r0, r1;
    int          cyc;
    xfer(1'b1, addr, data, WORD, rd, r0, r1, cyc, early);
    check("wr_resp", {30'd0, r1}, 32'd0);
    check("wr_cycles", cyc, 32'd3);
  endtask

  task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] data, early;
    logic [1:0]  r0, r1;
    int          cyc;
    exp_q.push_back(exp);
    xfer(1'b0, addr, 32'd0, WORD, data, r0, r1, cyc, early);
    check(tag, data, exp_q.pop_front());
    check({tag, "_resp"}, {30'd0, r1}, 32'd0);
  endtask

  task automatic err_xfer(input string tag, input logic w, input logic [31:0] addr,
                          input logic [31:0] data, input logic [2:0] size);
    logic [31:0] rdata, early;
    logic [1:0]  r0, r1;
    int          cyc;
    xfer(w, addr, data, size, rdata, r0, r1, cyc, early);
    check({tag, "_resp1"}, {30'd0, r0}, 32'd1);
    check({tag, "_resp2"}, {30'd0, r1}, 32'd1);
    check({tag, "_cycles"}, cyc, 32'd2);
    check({tag, "_rdata"}, rdata, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] data, early;
    logic [1:0]  r0, r1;
    int          cyc, cyc2, n;

    rst_n  = 1'b0;
    htrans = IDLE_T;
    hwrite = 1'b0;
    haddr  = '0;
    hsize  = WORD;
    hwdata = '0;
    repeat (3) @(posedge hclk);
    #1;

    // reset values
    check("rst_hready", {31'd0, hready_out}, 32'd1);
    check("rst_hresp", {30'd0, hresp}, 32'd0);
    check("rst_hrdata", hrdata, 32'd0);
    check("rst_interrupt", interrupt, 32'd0);
    check("rst_state", {30'd0, dbg_state}, 32'd0);
    rst_n = 1'b1;
    idle(1);

    // ID read: 3-cycle data phase, hrdata 0 until the completing cycle
    xfer(1'b0, 32'h1C, 32'd0, WORD, data, r0, r1, cyc, early);
    check("id_data", data, 32'hEFA0_0001);
    check("id_resp", {30'd0, r1}, 32'd0);
    check("id_cycles", cyc, 32'd3);
    check("id_early_rdata", early, 32'd0);

    // back-to-back: write SCRATCH, read SCRATCH presented during the write data phase
    htrans = NONSEQ; hwrite = 1'b1; haddr = 32'h00; hsize = WORD;
    @(posedge hclk); #1;
    hwdata = 32'hA5A5_5A5A;
    hwrite = 1'b0;
    haddr  = 32'h00;
    data_phase(cyc, r0, r1, data, early);
    @(posedge hclk); #1;
    htrans = IDLE_T;
    exp_q.push_back(32'hA5A5_5A5A);
    data_phase(cyc2, r0, r1, data, early);
    check("b2b_wr_cycles", cyc, 32'd3);
    check("b2b_rd_cycles", cyc2, 32'd3);
    check("b2b_rd_data", data, exp_q.pop_front());
    @(posedge hclk); #1;

    // error responses
    err_xfer("err_unmapped", 1'b0, 32'h20, 32'd0, WORD);
    err_xfer("err_wr_count", 1'b1, 32'h0C, 32'hFFFF_FFFF, WORD);
    err_xfer("err_size_rd", 1'b0, 32'h00, 32'd0, 3'b000);
    err_xfer("err_size_wr", 1'b1, 32'h00, 32'hDEAD_BEEF, 3'b001);
    err_xfer("err_rd_intset", 1'b0, 32'h14, 32'd0, WORD);
    rd("scratch_kept", 32'h00, 32'hA5A5_5A5A);
    rd("count_kept", 32'h0C, 32'd0);

    // one-shot timer: LOAD=5, MASK=1, CTRL=01
    wr(32'h08, 32'd5);
    wr(32'h18, 32'd1);
    wr(32'h04, 32'd1);
    // CTRL committed with COUNT=5: 5 decrements, then one more edge to interrupt
    n = 0;
    while (interrupt[0] !== 1'b1 && n < 20) begin
      @(posedge hclk); #1;
      n++;
    end
    check("oneshot_irq_delay", n, 32'd6);
    rd("oneshot_count_hold", 32'h0C, 32'd0);
    rd("oneshot_raw", 32'h10, 32'd1);

    // auto-reload, with a W1C landing on the expiry edge
    wr(32'h04, 32'd0);
    wr(32'h10, 32'd1);
    idle(1);
    check("irq_cleared", interrupt, 32'd0);
    wr(32'h04, 32'd3);
    // edges after commit: +1 reload 5, +2..+5 -> 4..1, +6 -> 0 and set;
    // a write started 2 edges later commits on +6
    idle(2);
    wr(32'h10, 32'd1);
    idle(1);
    check("set_beats_w1c", interrupt, 32'd1);
    rd("reload_count", 32'h0C, 32'd2);
    check("irq_stays_high", interrupt, 32'd1);

    // INT_SET / INT_MASK / W1C on bit 31
    wr(32'h04, 32'd0);
    wr(32'h10, 32'hFFFF_FFFF);
    wr(32'h18, 32'd0);
    idle(1);
    check("irq_all_clear", interrupt, 32'd0);
    wr(32'h14, 32'h8000_0000);
    idle(1);
    check("irq_masked", interrupt, 32'd0);
    rd("raw_bit31", 32'h10, 32'h8000_0000);
    wr(32'h18, 32'h8000_0000);
    idle(1);
    check("irq_bit31", interrupt, 32'h8000_0000);
    wr(32'h10, 32'h8000_0000);
    idle(1);
    check("irq_w1c31", interrupt, 32'd0);

    // reset during WAIT aborts the SCRATCH write
    wr(32'h04, 32'd2);
    htrans = NONSEQ; hwrite = 1'b1; haddr = 32'h00; hsize = WORD;
    @(posedge hclk); #1;
    htrans = IDLE_T;
    hwdata = 32'h1234_5678;
    check("wait_hready", {31'd0, hready_out}, 32'd0);
    check("wait_state", {30'd0, dbg_state}, 32'd1);
    rst_n = 1'b0;
    @(posedge hclk); #1;
    check("abort_hready", {31'd0, hready_out}, 32'd1);
    check("abort_state", {30'd0, dbg_state}, 32'd0);
    check("abort_hresp", {30'd0, hresp}, 32'd0);
    rst_n = 1'b1;
    rd("abort_scratch", 32'h00, 32'd0);
    rd("abort_ctrl", 32'h04, 32'd0);
    rd("abort_load", 32'h08, 32'd0);
    rd("abort_mask", 32'h18, 32'd0);
    rd("abort_raw", 32'h10, 32'd0);
    check("abort_irq", interrupt, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/eva_ahb_regbank.md
# eva_ahb_regbank

AHB-Lite slave register bank with a down-counting timer and a maskable interrupt vector. It sits directly downstream of the EVA AHB bus functional master and consumes its htrans/hwrite/haddr/hwdata transfers. It returns hready/hresp/hrdata to the master. Its `interrupt` vector feeds the EVA interrupt monitor, which reports rising edges to software.

## Interface
- BASE_ADDR, 32'h0000_0000, block is selected when haddr[31:8] == BASE_ADDR[31:8]
- WAIT_STATES, 0, extra wait cycles inserted in every OKAY data phase, legal range 0..3
- ID_VALUE, 32'hEFA0_0001, constant returned by the ID register
- hclk  in  1  clock; all logic on posedge
- rst_n  in  1  reset, synchronous, active-low
- htrans  in  2  AHB transfer type; NONSEQ/SEQ (htrans[1]=1) starts a transfer
- hwrite  in  1  1 = write
- haddr  in  32  byte address
- hsize  in  3  transfer size; only 3'b010 (word) is legal
- hwdata  in  32  write data, valid in the data phase
- hready_in  in  1  bus-level ready, used to qualify the address phase
- hready_out  out  1  slave ready; 0 = extend the data phase
- hresp  out  2  2'b00 OKAY, 2'b01 ERROR
- hrdata  out  32  read data
- interrupt  out  32  registered INT_RAW & INT_MASK

## Operation
- Address phase accepted when hready_in & htrans[1] & address match. haddr[7:2], hwrite and an error flag are latched at that point.
- The error flag is set for any of: unmapped offset, hsize != 3'b010, write to a read-only register, or read of INT_SET.
- Register map (byte offset):
  - 0x00 SCRATCH: RW, reset 0.
  - 0x04 CTRL: RW. [0] timer enable, [1] auto-reload, other bits read 0.
  - 0x08 LOAD: RW. A write also loads COUNT.
  - 0x0C COUNT: RO.
  - 0x10 INT_RAW: read returns the raw bits; a write clears each bit written as 1 (W1C).
  - 0x14 INT_SET: WO. Writing 1s ORs those bits into INT_RAW.
  - 0x18 INT_MASK: RW, reset 0.
  - 0x1C ID: RO, returns ID_VALUE.
- Data-phase FSM has four states: IDLE, WAIT, ERR1, ERR2.
  - IDLE: on an accepted OKAY transfer, go to WAIT when WAIT_STATES>0; otherwise complete in this cycle. On an accepted error transfer, go to ERR1.
  - WAIT: a counter runs from WAIT_STATES down to 1 with hready_out=0, then the phase completes.
  - ERR1: hready_out=0, hresp=01. Next state is ERR2.
  - ERR2: hready_out=1, hresp=01. Next state is IDLE. A transfer presented in ERR2 is not accepted.
- On an OKAY completion cycle:
  - Write data is committed from hwdata.
  - hrdata presents the register value for reads.
  - A new address phase may be accepted in the same cycle (back-to-back pipelining).
- Errored writes never modify state.
- Timer:
  - When CTRL[0]=1 and COUNT!=0, COUNT decrements by 1 each cycle.
  - The transition 1→0 sets INT_RAW[0].
  - When CTRL[0]=1, CTRL[1]=1 and COUNT==0, COUNT is loaded from LOAD in the next cycle.
  - When CTRL[1]=0, COUNT stays at 0.
- Simultaneous events:
  - INT_RAW: a hardware or INT_SET set in the same cycle as a W1C clear of the same bit → the set wins.
  - COUNT: a LOAD write takes priority over a decrement in the same cycle.

## Timing
- Reset values: hready_out=1, hresp=00, hrdata=0, interrupt=0, all registers 0, FSM=IDLE, wait counter=0.
- Reset asserted mid-transfer aborts it next edge; no partial write committed.
- OKAY latency: data phase lasts 1+WAIT_STATES cycles. Read data is valid only on the cycle with hready_out=1; hrdata is 0 otherwise.
- ERROR: always exactly 2 data-phase cycles, independent of WAIT_STATES.
- interrupt updates one cycle after INT_RAW or INT_MASK changes.
- COUNT value read is the registered value at the completion edge.

## Test plan
- Reset, then read ID at 0x1C → hrdata=32'hEFA0_0001, hresp=00, with a data phase of 1 cycle (WAIT_STATES=0) or 3 cycles (WAIT_STATES=2).
- Write SCRATCH=32'hA5A5_5A5A, then read back-to-back (pipelined NONSEQs) → 32'hA5A5_5A5A with no idle cycle between phases.
- Read 0x20, write COUNT (0x0C), and read with hsize=3'b000 → each gives a 2-cycle ERROR (01/ready0 then 01/ready1); SCRATCH is unchanged.
- LOAD=5, INT_MASK=1, CTRL=2'b01 → COUNT goes 5..0, INT_RAW[0]=1 on the 1→0 edge, interrupt[0]=1 one cycle later, COUNT holds 0.
- Same setup with CTRL=2'b11 → COUNT reloads to 5 and interrupt[0] stays high. Write INT_RAW=1 in the same cycle as the expiry → the bit stays set.
- INT_SET=32'h8000_0000 with INT_MASK=0 → interrupt=0. Then INT_MASK=32'h8000_0000 → interrupt[31]=1. Then W1C INT_RAW=32'h8000_0000 → interrupt=0. Assert rst_n=0 during the WAIT state → hready_out=1 next cycle and all registers are 0.
